// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: instruction fields arriving from MEM and the
// registered write-back results going to the register file.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [5:0]        opcode;
  logic              memToReg;
  logic              regWrite;
  logic [4:0]        dest_reg;
  logic [DATA_W-1:0] ALU_result;
  logic [DATA_W-1:0] mem_out;

  logic              wb_valid;
  logic              wb_regWrite;
  logic [4:0]        wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              align_err;
  logic [31:0]       retired_count;

  modport master (
    output stall, flush, in_valid, opcode, memToReg, regWrite, dest_reg,
           ALU_result, mem_out,
    input  wb_valid, wb_regWrite, wb_dest, wb_data, align_err, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, opcode, memToReg, regWrite, dest_reg,
           ALU_result, mem_out,
    output wb_valid, wb_regWrite, wb_dest, wb_data, align_err, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats big-endian load data, suppresses
// misaligned and $0 writes, and counts retired instructions.
module mem_wb_stage (
  input  logic           clk,
  input  logic           rst_n,
  mem_wb_stage_if.slave  bus
);
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;

  logic [31:0] data_d;
  logic        misaligned_d;
  logic        regwrite_d;

  logic        valid_q;
  logic        regwrite_q;
  logic [4:0]  dest_q;
  logic [31:0] data_q;
  logic        align_err_q;
  logic [31:0] count_q;

  // The addressed byte/halfword always sits at the top of mem_out.
  always_comb begin
    data_d = bus.ALU_result;
    if (bus.memToReg) begin
      case (bus.opcode)
        OP_LB:   data_d = {{24{bus.mem_out[31]}}, bus.mem_out[31:24]};
        OP_LBU:  data_d = {24'd0, bus.mem_out[31:24]};
        OP_LH:   data_d = {{16{bus.mem_out[31]}}, bus.mem_out[31:16]};
        OP_LHU:  data_d = {16'd0, bus.mem_out[31:16]};
        default: data_d = bus.mem_out;
      endcase
    end

    misaligned_d = 1'b0;
    case (bus.opcode)
      OP_LH, OP_LHU: misaligned_d = bus.in_valid & bus.ALU_result[0];
      OP_LW:         misaligned_d = bus.in_valid & (bus.ALU_result[1:0] != 2'b00);
      default:       misaligned_d = 1'b0;
    endcase

    regwrite_d = bus.in_valid & bus.regWrite & (bus.dest_reg != 5'd0) & ~misaligned_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      dest_q      <= 5'd0;
      data_q      <= 32'd0;
      align_err_q <= 1'b0;
      count_q     <= 32'd0;
    end else if (bus.flush) begin
      // Bubble wins over stall; sticky error and counter are left alone.
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      dest_q     <= 5'd0;
      data_q     <= 32'd0;
    end else if (!bus.stall) begin
      valid_q    <= bus.in_valid;
      regwrite_q <= regwrite_d;
      dest_q     <= bus.dest_reg;
      data_q     <= data_d;
      if (misaligned_d) begin
        align_err_q <= 1'b1;
      end
      if (bus.in_valid) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.wb_valid      = valid_q;
  assign bus.wb_regWrite   = regwrite_q;
  assign bus.wb_dest       = dest_q;
  assign bus.wb_data       = data_q;
  assign bus.align_err     = align_err_q;
  assign bus.retired_count = count_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed vector table, reset/wrap sequences,
// then randomized traffic against a rule-level reference model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if bus ();
  mem_wb_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        stall, flush, vld;
    logic [5:0]  op;
    logic        m2r, rw;
    logic [4:0]  dest;
    logic [31:0] alu, mem;
    logic        e_v, e_rw;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    logic        e_al;
    logic [31:0] e_cnt;
  } vec_t;

  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101, LW = 6'b100011, ALU = 6'b000000;
  localparam logic [31:0] MW = 32'h80FF1234;

  vec_t tbl[17];

  // Expected architectural state for the random phase.
  logic        m_v, m_rw, m_al;
  logic [4:0]  m_dest;
  logic [31:0] m_data, m_cnt;

  function automatic vec_t mk(logic s, logic f, logic v, logic [5:0] op, logic m2r, logic rw,
                              logic [4:0] d, logic [31:0] alu, logic [31:0] mem,
                              logic ev, logic erw, logic [4:0] ed, logic [31:0] edata,
                              logic eal, logic [31:0] ecnt);
    vec_t r;
    r.stall = s; r.flush = f; r.vld = v; r.op = op; r.m2r = m2r; r.rw = rw;
    r.dest = d; r.alu = alu; r.mem = mem; r.e_v = ev; r.e_rw = erw; r.e_dest = ed;
    r.e_data = edata; r.e_al = eal; r.e_cnt = ecnt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic f, logic v, logic [5:0] op, logic m2r, logic rw,
                       logic [4:0] d, logic [31:0] alu, logic [31:0] mem);
    bus.stall = s; bus.flush = f; bus.in_valid = v; bus.opcode = op;
    bus.memToReg = m2r; bus.regWrite = rw; bus.dest_reg = d;
    bus.ALU_result = alu; bus.mem_out = mem;
  endtask

  task automatic chk_all(string tag, logic ev, logic erw, logic [4:0] ed, logic [31:0] edata,
                         logic eal, logic [31:0] ecnt);
    chk({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, {31'd0, ev});
    chk({tag, ".wb_regWrite"}, {31'd0, bus.wb_regWrite}, {31'd0, erw});
    chk({tag, ".wb_dest"}, {27'd0, bus.wb_dest}, {27'd0, ed});
    chk({tag, ".wb_data"}, bus.wb_data, edata);
    chk({tag, ".align_err"}, {31'd0, bus.align_err}, {31'd0, eal});
    chk({tag, ".retired_count"}, bus.retired_count, ecnt);
  endtask

  // Load extraction straight from the opcode table, using signed casts.
  function automatic logic [31:0] ref_data(logic [5:0] op, logic m2r, logic [31:0] alu,
                                           logic [31:0] mem);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[31:24];
    h = mem[31:16];
    if (!m2r) return alu;
    if (op == LB)  return 32'(signed'(b));
    if (op == LBU) return 32'(b);
    if (op == LH)  return 32'(signed'(h));
    if (op == LHU) return 32'(h);
    return mem;
  endfunction

  function automatic logic ref_mis(logic [5:0] op, logic v, logic [31:0] alu);
    if (!v) return 1'b0;
    if (op == LH || op == LHU) return (alu % 2) != 0;
    if (op == LW) return (alu % 4) != 0;
    return 1'b0;
  endfunction

  initial begin
    tbl[0]  = mk(0,0,1,LB, 1,1,5'd3, 32'h10,  MW, 1,1,5'd3, 32'hFFFFFF80, 0, 1);
    tbl[1]  = mk(0,0,1,LBU,1,1,5'd4, 32'h20,  MW, 1,1,5'd4, 32'h00000080, 0, 2);
    tbl[2]  = mk(0,0,1,LH, 1,1,5'd4, 32'h20,  MW, 1,1,5'd4, 32'hFFFF80FF, 0, 3);
    tbl[3]  = mk(0,0,1,LHU,1,1,5'd4, 32'h20,  MW, 1,1,5'd4, 32'h000080FF, 0, 4);
    tbl[4]  = mk(0,0,1,LW, 1,1,5'd4, 32'h20,  MW, 1,1,5'd4, 32'h80FF1234, 0, 5);
    tbl[5]  = mk(0,0,1,ALU,0,1,5'd5, 32'h1234,32'hDEADBEEF, 1,1,5'd5, 32'h1234, 0, 6);
    tbl[6]  = mk(1,0,1,LW, 1,1,5'd6, 32'h22,  MW, 1,1,5'd5, 32'h1234, 0, 6);
    tbl[7]  = mk(1,0,1,ALU,0,1,5'd7, 32'h5555,MW, 1,1,5'd5, 32'h1234, 0, 6);
    tbl[8]  = mk(1,0,0,LB, 1,0,5'd0, 32'h0,   32'h0, 1,1,5'd5, 32'h1234, 0, 6);
    tbl[9]  = mk(1,1,1,ALU,0,1,5'd8, 32'h42,  MW, 0,0,5'd0, 32'h0, 0, 6);
    tbl[10] = mk(0,0,1,ALU,0,1,5'd0, 32'h77,  MW, 1,0,5'd0, 32'h77, 0, 7);
    tbl[11] = mk(0,0,1,LW, 1,1,5'd6, 32'h22,  MW, 1,0,5'd6, 32'h80FF1234, 1, 8);
    tbl[12] = mk(0,0,1,ALU,0,1,5'd7, 32'h99,  MW, 1,1,5'd7, 32'h99, 1, 9);
    tbl[13] = mk(0,1,1,LW, 1,1,5'd10,32'h20,  MW, 0,0,5'd0, 32'h0, 1, 9);
    tbl[14] = mk(0,0,0,ALU,0,1,5'd8, 32'h5,   MW, 0,0,5'd8, 32'h5, 1, 9);
    tbl[15] = mk(0,0,1,LH, 1,1,5'd9, 32'h21,  MW, 1,0,5'd9, 32'hFFFF80FF, 1, 10);
    tbl[16] = mk(0,0,1,LB, 1,1,5'd11,32'h23,  MW, 1,1,5'd11,32'hFFFFFF80, 1, 11);

    rst_n = 1'b0;
    drive(1,1,1,LW,1,1,5'd1,32'h3,MW);
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 0,0,5'd0,32'h0,0,32'h0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive(tbl[i].stall, tbl[i].flush, tbl[i].vld, tbl[i].op, tbl[i].m2r, tbl[i].rw,
            tbl[i].dest, tbl[i].alu, tbl[i].mem);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_rw, tbl[i].e_dest,
                 tbl[i].e_data, tbl[i].e_al, tbl[i].e_cnt);
    end

    // Reset during stall clears everything, including the sticky flag.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1,0,1,ALU,0,1,5'd3,32'h9,MW);
    @(posedge clk);
    #1 chk_all("rst_stall", 0,0,5'd0,32'h0,0,32'h0);

    // Counter wrap from a preloaded all-ones value.
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,1,ALU,0,1,5'd12,32'hAB,MW);
    force dut.count_q = 32'hFFFF_FFFF;
    #1 release dut.count_q;
    @(posedge clk);
    #1 chk_all("wrap", 1,1,5'd12,32'hAB,0,32'h0);

    m_v = 1; m_rw = 1; m_dest = 5'd12; m_data = 32'hAB; m_al = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      logic        s, f, v, m2r, rw, r;
      logic [5:0]  op;
      logic [4:0]  d;
      logic [31:0] alu, mem;
      logic [5:0]  ops[8];
      ops = '{LB, LBU, LH, LHU, LW, ALU, 6'b001101, 6'b101011};
      @(negedge clk);
      r   = ($urandom_range(0, 99) >= 3);
      s   = ($urandom_range(0, 99) < 20);
      f   = ($urandom_range(0, 99) < 10);
      v   = ($urandom_range(0, 99) < 80);
      op  = ops[$urandom_range(0, 7)];
      m2r = (op inside {LB, LBU, LH, LHU, LW}) ? 1'b1 : 1'($urandom);
      rw  = ($urandom_range(0, 99) < 85);
      d   = ($urandom_range(0, 99) < 10) ? 5'd0 : 5'($urandom);
      alu = $urandom;
      mem = $urandom;
      rst_n = r;
      drive(s, f, v, op, m2r, rw, d, alu, mem);
      if (!r) begin
        m_v = 0; m_rw = 0; m_dest = 0; m_data = 0; m_al = 0; m_cnt = 0;
      end else if (f) begin
        m_v = 0; m_rw = 0; m_dest = 0; m_data = 0;
      end else if (!s) begin
        m_v    = v;
        m_rw   = v && rw && d != 0 && !ref_mis(op, v, alu);
        m_dest = d;
        m_data = ref_data(op, m2r, alu, mem);
        m_al   = m_al || ref_mis(op, v, alu);
        m_cnt  = m_cnt + (v ? 32'd1 : 32'd0);
      end
      @(posedge clk);
      #1 chk_all($sformatf("rnd%0d", n), m_v, m_rw, m_dest, m_data, m_al, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
